// File: rtl/issue_scheduler_pkg.sv
// Shared sizing helpers for the issue scheduler: functional-unit count and
// round-robin pointer width, plus the default-configuration values.
package issue_scheduler_pkg;

  localparam int DEF_EXEC_WIDTH = 4;
  localparam int DEF_REQ_COUNT  = 4;

  // One functional unit per execution ID value.
  function automatic int unit_count(input int exec_width);
    return 1 << exec_width;
  endfunction

  // Pointer wide enough to name every requesting slot.
  function automatic int ptr_width(input int req_count);
    return (req_count > 1) ? $clog2(req_count) : 1;
  endfunction

  localparam int NUM_UNITS = unit_count(DEF_EXEC_WIDTH);
  localparam int RR_PTR_W  = ptr_width(DEF_REQ_COUNT);

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Rotate-priority arbiter: the first eligible slot at or after rr_ptr
// (wrapping) wins. Purely combinational. N must be a power of two so the
// pointer arithmetic wraps on its own.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // rot[j] is the eligibility of slot (rr_ptr + j) mod N.
  assign dbl = {eligible, eligible} >> rr_ptr;
  assign rot = dbl[N-1:0];

  // Scan from the far end so the lowest rotated offset is written last.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        grant_idx = rr_ptr + PW'(j);
        grant_any = 1'b1;
      end
    end
  end

  // One-hot expansion of the winner.
  always_comb begin
    grant = '0;
    grant[grant_idx] = grant_any;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: round-robin grant of ready reservation-station slots to
// free functional units, registered dispatch beat, per-unit busy scoreboard.
// Optional feature macro: ISSUE_SCHED_STALL_COUNT_EN adds a saturating
// 32-bit stall_count output.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int EXEC_WIDTH = DEF_EXEC_WIDTH,
  parameter int REQ_COUNT  = DEF_REQ_COUNT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   halt,
  input  logic                                   flush,
  input  logic [REQ_COUNT-1:0]                   req_valid,
  input  logic [REQ_COUNT-1:0][EXEC_WIDTH-1:0]   req_executionID,
  input  logic [REQ_COUNT-1:0][TAG_WIDTH-1:0]    req_executionTag,
  input  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]   req_op1,
  input  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]   req_op2,
  output logic [REQ_COUNT-1:0]                   grant,
  input  logic [unit_count(EXEC_WIDTH)-1:0]      availableFunctionalUnits,
  input  logic [unit_count(EXEC_WIDTH)-1:0]      fu_done,
  output logic                                   dispatch,
  output logic [DATA_WIDTH-1:0]                  op1,
  output logic [DATA_WIDTH-1:0]                  op2,
  output logic [EXEC_WIDTH-1:0]                  executionID,
  output logic [TAG_WIDTH-1:0]                   executionTag,
  output logic [unit_count(EXEC_WIDTH)-1:0]      fu_busy
`ifdef ISSUE_SCHED_STALL_COUNT_EN
  ,
  output logic [31:0]                            stall_count
`endif
);

  localparam int UNITS = unit_count(EXEC_WIDTH);
  localparam int PW    = ptr_width(REQ_COUNT);

  logic [1:0]           rst_pipe;
  logic                 run;
  logic [PW-1:0]        rr_ptr;
  logic [REQ_COUNT-1:0] eligible;
  logic [PW-1:0]        grant_idx;
  logic                 grant_any;
  logic [EXEC_WIDTH-1:0] grant_unit;
  logic [UNITS-1:0]     busy_next;

  // Reset synchronizer: assert immediately, release two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= '0;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign run = rst_pipe[1];

  // A slot competes only if its unit is present, idle, and nothing freezes issue.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      eligible[i] = req_valid[i]
                 && availableFunctionalUnits[req_executionID[i]]
                 && !fu_busy[req_executionID[i]]
                 && run && !halt && !flush;
    end
  end

  rr_arbiter #(.N(REQ_COUNT), .PW(PW)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign grant_unit = req_executionID[grant_idx];

  // Completions clear first; a new issue sets its unit (never the same unit).
  always_comb begin
    busy_next = fu_busy & ~fu_done;
    if (grant_any) busy_next[grant_unit] = 1'b1;
  end

  // Pointer, scoreboard and the registered dispatch beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      fu_busy      <= '0;
      dispatch     <= 1'b0;
      op1          <= '0;
      op2          <= '0;
      executionID  <= '0;
      executionTag <= '0;
    end else begin
      fu_busy  <= busy_next;
      dispatch <= grant_any;
      if (flush)          rr_ptr <= '0;
      else if (grant_any) rr_ptr <= grant_idx + PW'(1);
      if (grant_any) begin
        op1          <= req_op1[grant_idx];
        op2          <= req_op2[grant_idx];
        executionID  <= grant_unit;
        executionTag <= req_executionTag[grant_idx];
      end
    end
  end

`ifdef ISSUE_SCHED_STALL_COUNT_EN
  logic stall_hit;
  assign stall_hit = (|req_valid) && !halt && !flush && !grant_any;

  // Saturating count of cycles where work was offered but nothing issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              stall_count <= '0;
    else if (stall_hit && ~&stall_count)   stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Arbitrates between reservation-station slots that hold ready operands and compete for the execution units. Each cycle it grants at most one slot and drives a registered dispatch beat (operands, execution ID, tag) into the dispatch unit. It keeps a busy scoreboard per functional unit, set on issue and cleared on completion, so that a unit never receives two operations in flight.

## Interface
- DATA_WIDTH, 32, operand width
- TAG_WIDTH, 7, ROB tag width
- EXEC_WIDTH, 4, execution-ID width; 2**EXEC_WIDTH functional units
- REQ_COUNT, 4, requesting slots (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- halt  in  1  freeze: no grant, all state held
- flush  in  1  drop the pending dispatch beat and the round-robin state
- req_valid  in  REQ_COUNT  slot i holds a ready operation
- req_executionID  in  REQ_COUNT*EXEC_WIDTH  target unit per slot
- req_executionTag  in  REQ_COUNT*TAG_WIDTH  ROB tag per slot
- req_op1, req_op2  in  REQ_COUNT*DATA_WIDTH  operands per slot
- grant  out  REQ_COUNT  one-hot, combinational, same-cycle acceptance
- availableFunctionalUnits  in  2**EXEC_WIDTH  unit present/ready, from the dispatch unit
- fu_done  in  2**EXEC_WIDTH  one-cycle pulse when a unit completes
- dispatch  out  1  registered dispatch strobe
- op1, op2  out  DATA_WIDTH  registered operands
- executionID  out  EXEC_WIDTH  registered target unit
- executionTag  out  TAG_WIDTH  registered ROB tag
- fu_busy  out  2**EXEC_WIDTH  scoreboard state

## Operation
- Eligibility of slot i: req_valid[i] && availableFunctionalUnits[id_i] && !fu_busy[id_i] && !halt && !flush.
- Round-robin: search starts at rr_ptr and wraps modulo REQ_COUNT. The first eligible slot receives grant.
- On a grant to slot g: rr_ptr ← (g+1) mod REQ_COUNT. Without a grant, rr_ptr holds.
- The requester treats grant as consumed in the same cycle. It may present a new operation in the next cycle.
- Two eligible slots that target the same free unit: only the first in round-robin order wins. The other stays pending.
- Scoreboard: grant to unit u sets fu_busy[u] at the clock edge. fu_done[u] clears it at the edge.
- Same-edge fu_done[u] and grant to u cannot occur, because u is busy in that cycle. The clear takes effect first, and u is eligible from the next cycle.
- fu_done on a unit that is not busy is ignored.
- flush:
  - dispatch ← 0 on the next edge.
  - rr_ptr ← 0.
  - grant forced to 0.
  - fu_busy is NOT cleared, because units in flight still complete.
- halt:
  - grant = 0.
  - dispatch ← 0.
  - rr_ptr and fu_busy hold.
  - fu_done still clears busy bits.
- flush has priority over halt.

## Timing
- Reset (rst=0, asynchronous):
  - dispatch=0, op1=0, op2=0, executionID=0, executionTag=0.
  - fu_busy=0, rr_ptr=0.
  - grant=0, since it is gated by internal reset state.
- Grant in cycle T produces dispatch=1 with the slot's fields in cycle T+1. Latency is 1.
- dispatch is high for exactly one cycle per grant. Back-to-back grants to different units give dispatch high on consecutive cycles.
- Minimum reissue interval to one unit: grant at T, fu_done at T+k, next grant at T+k+1 or later.
- Reset asserted mid-operation: state clears immediately. Deassertion is synchronous to clk through the top-level reset synchronizer.

## Configuration
- ISSUE_SCHED_STALL_COUNT_EN
  - Defined:
    - Adds the output stall_count (32 bits).
    - It increments, saturating at 2**32−1, on every cycle with |req_valid && !halt && !flush && grant==0.
    - Reset value 0. flush does not clear it.
  - Undefined: the port and the counter are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package: the EXEC_WIDTH-derived unit count and the round-robin pointer width ($clog2(REQ_COUNT)).
- One sub-module: rr_arbiter.
  - Combinational rotate-priority pick.
  - Inputs: the eligible vector and rr_ptr.
  - Outputs: the one-hot grant and the encoded index.
- The scoreboard, output registers and counter stay in issue_scheduler.

## Test plan
- Reset release, no requests → dispatch=0, fu_busy=0, grant=0 for 10 cycles.
- Single request, slot 2 → unit 5, operands 0x11/0x22, tag 9:
  - grant=4'b0100 in cycle T.
  - Cycle T+1: dispatch=1, op1=0x11, op2=0x22, executionID=5, executionTag=9.
  - fu_busy[5]=1.
- Slots 0–3 valid, all targeting distinct free units, rr_ptr=0 → grants 0,1,2,3 on consecutive cycles, then rr_ptr=0.
- Slots 1 and 3 → unit 2, rr_ptr=2:
  - Slot 3 wins.
  - Slot 1 is blocked until fu_done[2] at cycle X, then granted at X+1.
- halt for 3 cycles with a valid request → no grant, no dispatch. Granted on the first cycle after halt.
- flush while a grant is pending:
  - dispatch=0 the next cycle, rr_ptr=0.
  - The fu_busy bit set by the previous grant persists until fu_done.
  - With the macro defined, stall_count increments only on the qualifying cycles.
